// File: rtl/drop_ctrl.sv
// Gravity/drop sequencer: turns fall-timer timeouts and soft/hard drop pulses into
// down-step handshakes with the board, applies the lock delay and pulses lock.
`timescale 1ns/1ps
module drop_ctrl #(
    parameter int LOCK_CYCLES = 50_000_000,
    parameter int CNT_W       = 26,
    parameter int ROWS_W      = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              timeout,
    input  logic              soft_drop,
    input  logic              hard_drop,
    input  logic              piece_moved,
    input  logic              down_ack,
    input  logic              down_blocked,
    output logic              down_req,
    output logic              timer_rst,
    output logic              lock,
    output logic [ROWS_W-1:0] drop_rows
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WAIT  = 3'd1,
        S_REQ   = 3'd2,
        S_HGAP  = 3'd3,
        S_DELAY = 3'd4,
        S_LOCK  = 3'd5
    } state_t;

    localparam logic [CNT_W-1:0]  LOCK_LAST = CNT_W'(LOCK_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [ROWS_W-1:0] ROWS_MAX  = {ROWS_W{1'b1}};
    localparam logic [ROWS_W-1:0] ROWS_ONE  = {{(ROWS_W-1){1'b0}}, 1'b1};

    state_t             state_q, state_d;
    logic               down_req_q, down_req_d;
    logic               timer_rst_q, timer_rst_d;
    logic               lock_q, lock_d;
    logic [ROWS_W-1:0]  drop_rows_q, drop_rows_d;
    logic [CNT_W-1:0]   lock_cnt_q, lock_cnt_d;
    logic               hard_active_q, hard_active_d;
    logic               src_drop_q, src_drop_d;
    logic               timeout_s;

    // While the restart pulse is out, the timer has not cleared yet: its level is stale.
    assign timeout_s = timeout & ~timer_rst_q;

    assign down_req  = down_req_q;
    assign timer_rst = timer_rst_q;
    assign lock      = lock_q;
    assign drop_rows = drop_rows_q;

    // Next-state and next-output logic of the drop sequencer.
    always_comb begin
        state_d       = state_q;
        down_req_d    = 1'b0;
        timer_rst_d   = 1'b0;
        lock_d        = 1'b0;
        drop_rows_d   = drop_rows_q;
        lock_cnt_d    = lock_cnt_q;
        hard_active_d = hard_active_q;
        src_drop_d    = src_drop_q;
        case (state_q)
            S_IDLE: begin
                if (enable) begin
                    state_d     = S_WAIT;
                    timer_rst_d = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_WAIT: begin
                if (!enable) begin
                    state_d = S_IDLE;
                end else if (hard_drop) begin
                    state_d       = S_REQ;
                    down_req_d    = 1'b1;
                    hard_active_d = 1'b1;
                    src_drop_d    = 1'b1;
                end else if (soft_drop) begin
                    state_d    = S_REQ;
                    down_req_d = 1'b1;
                    src_drop_d = 1'b1;
                end else if (timeout_s) begin
                    state_d    = S_REQ;
                    down_req_d = 1'b1;
                    src_drop_d = 1'b0;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_REQ: begin
                if (down_ack && !down_blocked && src_drop_q && (drop_rows_q != ROWS_MAX)) begin
                    drop_rows_d = drop_rows_q + ROWS_ONE;
                end else begin
                    drop_rows_d = drop_rows_q;
                end
                if (!down_ack) begin
                    down_req_d = 1'b1;
                end else if (!enable) begin
                    state_d = S_IDLE;
                end else if (!down_blocked) begin
                    if (hard_active_q) begin
                        state_d = S_HGAP;
                    end else begin
                        state_d     = S_WAIT;
                        timer_rst_d = 1'b1;
                    end
                end else if (hard_active_q) begin
                    state_d = S_LOCK;
                    lock_d  = 1'b1;
                end else begin
                    // Restart the timer too, so a still-high timeout does not re-probe at once.
                    state_d     = S_DELAY;
                    lock_cnt_d  = {CNT_W{1'b0}};
                    timer_rst_d = 1'b1;
                end
            end
            S_HGAP: begin
                state_d    = S_REQ;
                down_req_d = 1'b1;
            end
            S_DELAY: begin
                lock_cnt_d = lock_cnt_q + CNT_ONE;
                if (!enable) begin
                    state_d = S_IDLE;
                end else if (hard_drop) begin
                    state_d = S_LOCK;
                    lock_d  = 1'b1;
                end else if (piece_moved) begin
                    state_d     = S_WAIT;
                    timer_rst_d = 1'b1;
                end else if (soft_drop) begin
                    state_d    = S_REQ;
                    down_req_d = 1'b1;
                    src_drop_d = 1'b1;
                end else if (timeout_s) begin
                    state_d    = S_REQ;
                    down_req_d = 1'b1;
                    src_drop_d = 1'b0;
                end else if (lock_cnt_q == LOCK_LAST) begin
                    state_d = S_LOCK;
                    lock_d  = 1'b1;
                end else begin
                    state_d = S_DELAY;
                end
            end
            S_LOCK: begin
                drop_rows_d   = {ROWS_W{1'b0}};
                hard_active_d = 1'b0;
                timer_rst_d   = 1'b1;
                if (enable) begin
                    state_d = S_WAIT;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and registered outputs; async reset drops any request in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            down_req_q    <= 1'b0;
            timer_rst_q   <= 1'b0;
            lock_q        <= 1'b0;
            drop_rows_q   <= {ROWS_W{1'b0}};
            lock_cnt_q    <= {CNT_W{1'b0}};
            hard_active_q <= 1'b0;
            src_drop_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            down_req_q    <= down_req_d;
            timer_rst_q   <= timer_rst_d;
            lock_q        <= lock_d;
            drop_rows_q   <= drop_rows_d;
            lock_cnt_q    <= lock_cnt_d;
            hard_active_q <= hard_active_d;
            src_drop_q    <= src_drop_d;
        end
    end

endmodule

// File: tb/tb_drop_ctrl.sv
// Directed bench for drop_ctrl with a short lock delay (10 cycles) and 5-bit drop_rows.
`timescale 1ns/1ps
module tb_drop_ctrl;

    logic       clk;
    logic       rst;
    logic       enable;
    logic       timeout;
    logic       soft_drop;
    logic       hard_drop;
    logic       piece_moved;
    logic       down_ack;
    logic       down_blocked;
    logic       down_req;
    logic       timer_rst;
    logic       lock;
    logic [4:0] drop_rows;

    int n_checks = 0;
    int n_fails  = 0;

    drop_ctrl #(.LOCK_CYCLES(10), .CNT_W(4), .ROWS_W(5)) dut (
        .clk(clk), .rst(rst), .enable(enable), .timeout(timeout),
        .soft_drop(soft_drop), .hard_drop(hard_drop), .piece_moved(piece_moved),
        .down_ack(down_ack), .down_blocked(down_blocked), .down_req(down_req),
        .timer_rst(timer_rst), .lock(lock), .drop_rows(drop_rows)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 ns after each rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        rst = 1'b1; enable = 1'b0; timeout = 1'b0; soft_drop = 1'b0; hard_drop = 1'b0;
        piece_moved = 1'b0; down_ack = 1'b0; down_blocked = 1'b0;
        step();
        rst = 1'b0;
        step();
    endtask

    // IDLE -> WAIT, then let the restart pulse pass.
    task automatic go_wait();
        enable = 1'b1;
        step();
        step();
    endtask

    task automatic test_reset();
        reset_dut();
        n_checks += 4;
        if (down_req !== 1'b0) begin n_fails++; $display("FAIL rst_down_req: got %b want 0", down_req); end
        if (timer_rst !== 1'b0) begin n_fails++; $display("FAIL rst_timer_rst: got %b want 0", timer_rst); end
        if (lock !== 1'b0) begin n_fails++; $display("FAIL rst_lock: got %b want 0", lock); end
        if (drop_rows !== 5'd0) begin n_fails++; $display("FAIL rst_drop_rows: got %0d want 0", drop_rows); end
        enable = 1'b1;
        step();
        n_checks++;
        if (timer_rst !== 1'b1) begin n_fails++; $display("FAIL idle_to_wait_timer_rst: got %b want 1", timer_rst); end
        step();
        timeout = 1'b1;
        step();
        n_checks++;
        if (down_req !== 1'b1) begin n_fails++; $display("FAIL rst_pre_req: got %b want 1", down_req); end
        #2 rst = 1'b1;
        #1;
        n_checks += 3;
        if (down_req !== 1'b0) begin n_fails++; $display("FAIL rst_mid_down_req: got %b want 0", down_req); end
        if (lock !== 1'b0) begin n_fails++; $display("FAIL rst_mid_lock: got %b want 0", lock); end
        if (timer_rst !== 1'b0) begin n_fails++; $display("FAIL rst_mid_timer_rst: got %b want 0", timer_rst); end
        step();
        rst = 1'b0; timeout = 1'b0; enable = 1'b0;
        step();
        step();
        n_checks++;
        if (down_req !== 1'b0 || timer_rst !== 1'b0) begin
            n_fails++; $display("FAIL rst_idle_quiet: down_req=%b timer_rst=%b want 0 0", down_req, timer_rst);
        end
        enable = 1'b1;
        step();
        n_checks++;
        if (timer_rst !== 1'b1) begin n_fails++; $display("FAIL rst_back_in_idle: timer_rst=%b want 1", timer_rst); end
    endtask

    task automatic test_gravity();
        reset_dut();
        go_wait();
        timeout = 1'b1;
        step();
        step();
        n_checks++;
        if (down_req !== 1'b1) begin n_fails++; $display("FAIL grav_req_held: got %b want 1", down_req); end
        down_ack = 1'b1; down_blocked = 1'b0;
        step();
        down_ack = 1'b0;
        n_checks += 3;
        if (down_req !== 1'b0) begin n_fails++; $display("FAIL grav_req_drop: got %b want 0", down_req); end
        if (timer_rst !== 1'b1) begin n_fails++; $display("FAIL grav_timer_rst: got %b want 1", timer_rst); end
        if (drop_rows !== 5'd0) begin n_fails++; $display("FAIL grav_drop_rows: got %0d want 0", drop_rows); end
        timeout = 1'b0;
        step();
        n_checks++;
        if (timer_rst !== 1'b0 || down_req !== 1'b0) begin
            n_fails++; $display("FAIL grav_pulse_end: timer_rst=%b down_req=%b want 0 0", timer_rst, down_req);
        end
    endtask

    // Enter DELAY through a blocked gravity step; returns in DELAY cycle 0.
    task automatic enter_delay();
        timeout = 1'b1;
        step();
        down_ack = 1'b1; down_blocked = 1'b1;
        step();
        down_ack = 1'b0; down_blocked = 1'b0; timeout = 1'b0;
    endtask

    task automatic test_lock_delay();
        reset_dut();
        go_wait();
        enter_delay();
        for (int i = 1; i <= 10; i++) begin
            step();
            n_checks++;
            if (lock !== ((i == 10) ? 1'b1 : 1'b0)) begin
                n_fails++; $display("FAIL delay_lock_cycle%0d: got %b want %b", i, lock, (i == 10));
            end
        end
        n_checks++;
        if (drop_rows !== 5'd0) begin n_fails++; $display("FAIL delay_drop_rows: got %0d want 0", drop_rows); end
        step();
        n_checks++;
        if (lock !== 1'b0 || timer_rst !== 1'b1) begin
            n_fails++; $display("FAIL delay_after_lock: lock=%b timer_rst=%b want 0 1", lock, timer_rst);
        end
        reset_dut();
        go_wait();
        enter_delay();
        for (int i = 1; i <= 5; i++) step();
        piece_moved = 1'b1;
        step();
        piece_moved = 1'b0;
        n_checks++;
        if (timer_rst !== 1'b1 || lock !== 1'b0) begin
            n_fails++; $display("FAIL moved_wait: timer_rst=%b lock=%b want 1 0", timer_rst, lock);
        end
        for (int i = 0; i < 8; i++) begin
            step();
            n_checks++;
            if (lock !== 1'b0 || down_req !== 1'b0) begin
                n_fails++; $display("FAIL moved_no_lock: lock=%b down_req=%b want 0 0", lock, down_req);
            end
        end
    endtask

    task automatic test_reprobe();
        reset_dut();
        go_wait();
        enter_delay();
        for (int i = 1; i <= 6; i++) step();
        soft_drop = 1'b1;
        step();
        soft_drop = 1'b0;
        n_checks++;
        if (down_req !== 1'b1) begin n_fails++; $display("FAIL reprobe_req: got %b want 1", down_req); end
        down_ack = 1'b1;
        step();
        down_ack = 1'b0;
        n_checks++;
        if (timer_rst !== 1'b1 || drop_rows !== 5'd1) begin
            n_fails++; $display("FAIL reprobe_wait: timer_rst=%b drop_rows=%0d want 1 1", timer_rst, drop_rows);
        end
        step();
        enter_delay();
        for (int i = 1; i <= 10; i++) begin
            step();
            n_checks++;
            if (lock !== ((i == 10) ? 1'b1 : 1'b0)) begin
                n_fails++; $display("FAIL reentry_lock_cycle%0d: got %b want %b", i, lock, (i == 10));
            end
        end
        n_checks++;
        if (drop_rows !== 5'd1) begin n_fails++; $display("FAIL reentry_drop_rows: got %0d want 1", drop_rows); end
    endtask

    task automatic test_hard_drop();
        reset_dut();
        go_wait();
        hard_drop = 1'b1;
        step();
        hard_drop = 1'b0;
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if (down_req !== 1'b1) begin n_fails++; $display("FAIL hard_req%0d: got %b want 1", k, down_req); end
            down_ack = 1'b1; down_blocked = (k == 3);
            step();
            down_ack = 1'b0; down_blocked = 1'b0;
            if (k < 3) begin
                n_checks++;
                if (down_req !== 1'b0 || lock !== 1'b0) begin
                    n_fails++; $display("FAIL hard_gap%0d: down_req=%b lock=%b want 0 0", k, down_req, lock);
                end
                step();
            end else begin
                n_checks += 2;
                if (lock !== 1'b1) begin n_fails++; $display("FAIL hard_lock: got %b want 1", lock); end
                if (drop_rows !== 5'd3) begin n_fails++; $display("FAIL hard_rows: got %0d want 3", drop_rows); end
            end
        end
        step();
        n_checks++;
        if (lock !== 1'b0 || drop_rows !== 5'd0 || timer_rst !== 1'b1) begin
            n_fails++;
            $display("FAIL hard_after: lock=%b drop_rows=%0d timer_rst=%b want 0 0 1", lock, drop_rows, timer_rst);
        end
    endtask

    task automatic test_priority();
        reset_dut();
        go_wait();
        hard_drop = 1'b1; timeout = 1'b1;
        step();
        hard_drop = 1'b0;
        down_ack = 1'b1;
        step();
        down_ack = 1'b0;
        n_checks++;
        if (down_req !== 1'b0 || timer_rst !== 1'b0) begin
            n_fails++; $display("FAIL prio_hard_gap: down_req=%b timer_rst=%b want 0 0", down_req, timer_rst);
        end
        step();
        down_ack = 1'b1; down_blocked = 1'b1;
        step();
        down_ack = 1'b0; down_blocked = 1'b0;
        n_checks++;
        if (lock !== 1'b1 || drop_rows !== 5'd1) begin
            n_fails++; $display("FAIL prio_hard_lock: lock=%b drop_rows=%0d want 1 1", lock, drop_rows);
        end
        reset_dut();
        go_wait();
        soft_drop = 1'b1; timeout = 1'b1;
        step();
        soft_drop = 1'b0;
        down_ack = 1'b1;
        step();
        down_ack = 1'b0;
        n_checks++;
        if (down_req !== 1'b0 || timer_rst !== 1'b1 || drop_rows !== 5'd1) begin
            n_fails++;
            $display("FAIL prio_soft: down_req=%b timer_rst=%b drop_rows=%0d want 0 1 1", down_req, timer_rst, drop_rows);
        end
        timeout = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            n_checks++;
            if (down_req !== 1'b0) begin n_fails++; $display("FAIL prio_single_req: got %b want 0", down_req); end
        end
    endtask

    task automatic test_pause();
        reset_dut();
        go_wait();
        timeout = 1'b1;
        step();
        enable = 1'b0; timeout = 1'b0;
        step();
        step();
        n_checks++;
        if (down_req !== 1'b1) begin n_fails++; $display("FAIL pause_req_held: got %b want 1", down_req); end
        down_ack = 1'b1;
        step();
        down_ack = 1'b0;
        n_checks++;
        if (down_req !== 1'b0 || lock !== 1'b0 || timer_rst !== 1'b0) begin
            n_fails++;
            $display("FAIL pause_ack_idle: down_req=%b lock=%b timer_rst=%b want 0 0 0", down_req, lock, timer_rst);
        end
        step();
        enable = 1'b1;
        step();
        n_checks++;
        if (timer_rst !== 1'b1) begin n_fails++; $display("FAIL pause_resume: timer_rst=%b want 1", timer_rst); end
        reset_dut();
        go_wait();
        enter_delay();
        step();
        step();
        enable = 1'b0;
        for (int i = 0; i < 12; i++) begin
            step();
            n_checks++;
            if (lock !== 1'b0) begin n_fails++; $display("FAIL pause_delay_lock: got %b want 0", lock); end
        end
        enable = 1'b1;
        step();
        n_checks++;
        if (timer_rst !== 1'b1) begin n_fails++; $display("FAIL pause_delay_idle: timer_rst=%b want 1", timer_rst); end
    endtask

    task automatic test_saturate();
        reset_dut();
        go_wait();
        hard_drop = 1'b1;
        step();
        hard_drop = 1'b0;
        for (int k = 0; k < 33; k++) begin
            down_ack = 1'b1;
            step();
            down_ack = 1'b0;
            step();
        end
        n_checks++;
        if (drop_rows !== 5'd31) begin n_fails++; $display("FAIL sat_rows: got %0d want 31", drop_rows); end
        down_ack = 1'b1; down_blocked = 1'b1;
        step();
        down_ack = 1'b0; down_blocked = 1'b0;
        n_checks++;
        if (lock !== 1'b1 || drop_rows !== 5'd31) begin
            n_fails++; $display("FAIL sat_lock: lock=%b drop_rows=%0d want 1 31", lock, drop_rows);
        end
    endtask

    initial begin
        test_reset();
        test_gravity();
        test_lock_delay();
        test_reprobe();
        test_hard_drop();
        test_priority();
        test_pause();
        test_saturate();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached before end of test");
        $fatal(1, "watchdog expired");
    end

endmodule
